sa_out_deskew: RTL

// - Receive end of the systolic-array datapath: collects the diagonally skewed result words shifted out
//   of the bottom of the SA (one 16-bit word per column per PE shift) and rebuilds the (X_R,N) product matrix.
// - Counterpart of the input skew feeder; sits between SA.O_OUT/O_SHIFT and the wrapper O_OUT/O_OUT_VLD.
// - Data is Q2.13 (1 sign, 2 int, 13 frac); words are stored unmodified.

---
 rtl/sa_out_deskew.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sa_out_deskew.sv
// -----------------------------------------------------------------------------
// sa_out_deskew
//
// Receive end of the systolic-array datapath. The SA shifts one 16-bit word per
// column out of its bottom edge on every PE shift, but the results leave
// diagonally skewed: element (r,c) appears on lane c during the shift where the
// shift counter k equals LAT + r + c. This block undoes that skew and rebuilds
// the X_R x N product matrix. Words (Q2.13) are stored unmodified.
//
// Ports
//   I_CLK         in   1          clock, all state on rising edge
//   I_RST_N       in   1          asynchronous active-low reset
//   I_START_FLAG  in   1          start of a new product (restarts from any state)
//   I_SHIFT       in   1          SA PE-shift strobe, one row-word per pulse
//   I_SA_OUT      in   N*16       SA bottom outputs, lane c = [c*16 +: 16]
//   O_OUT         out  X_R*N*16   rebuilt matrix, (r,c) = [(r*N+c)*16 +: 16]
//   O_OUT_VLD     out  1          O_OUT complete and stable (level)
//   O_BUSY        out  1          collection in progress
//   O_ERR         out  1          only when SA_DESKEW_ERR_EN is defined
//
// Configuration macro: SA_DESKEW_ERR_EN
//   Defined   : O_ERR port present; a nonzero word on any lane outside its
//               capture window during an accepted shift sets a sticky error,
//               cleared by reset or I_START_FLAG.
//   Undefined : no O_ERR port; out-of-window lanes are ignored.
// -----------------------------------------------------------------------------
module sa_out_deskew #(
   parameter int S   = 64,
   parameter int X_R = 64,
   parameter int N   = 64,
   parameter int LAT = S
) (
   input  logic                 I_CLK,
   input  logic                 I_RST_N,
   input  logic                 I_START_FLAG,
   input  logic                 I_SHIFT,
   input  logic [N*16-1:0]      I_SA_OUT,
   output logic [X_R*N*16-1:0]  O_OUT,
   output logic                 O_OUT_VLD,
   output logic                 O_BUSY
`ifdef SA_DESKEW_ERR_EN
   ,
   output logic                 O_ERR
`endif
);

   localparam int            KW     = $clog2(LAT + X_R + N);
   localparam logic [KW-1:0] K_LAST = KW'(LAT + X_R + N - 2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [KW-1:0] r_k;
   logic          w_shift_acc;
   logic [15:0]   r_out [X_R*N];

   // A start in the same cycle as a shift wins; the shift is dropped.
   assign w_shift_acc = (r_state == ST_COLLECT) && I_SHIFT && !I_START_FLAG;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      if (I_START_FLAG) begin
         w_state_next = ST_COLLECT;
      end else if (w_shift_acc && (r_k == K_LAST)) begin
         w_state_next = ST_DONE;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      O_BUSY    = (r_state == ST_COLLECT);
      O_OUT_VLD = (r_state == ST_DONE);
   end

   // Shift counter; only advances on shifts accepted while collecting, so SA
   // stalls between shifts simply hold everything.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_k <= '0;
      end else if (I_START_FLAG) begin
         r_k <= '0;
      end else if (w_shift_acc) begin
         r_k <= r_k + 1'b1;
      end
   end

   // Each matrix element has exactly one shift index at which it is present on
   // its lane, so every element register gets a single constant compare.
   genvar gi, gj;
   generate
      for (gi = 0; gi < X_R; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            localparam logic [KW-1:0] K_HIT = KW'(LAT + gi + gj);
            always_ff @(posedge I_CLK or negedge I_RST_N) begin
               if (!I_RST_N) begin
                  r_out[gi*N+gj] <= '0;
               end else if (w_shift_acc && (r_k == K_HIT)) begin
                  r_out[gi*N+gj] <= I_SA_OUT[gj*16 +: 16];
               end
            end
            assign O_OUT[(gi*N+gj)*16 +: 16] = r_out[gi*N+gj];
         end
      end
   endgenerate

`ifdef SA_DESKEW_ERR_EN
   logic [N-1:0] w_lane_bad;
   logic         r_err;

   generate
      for (gj = 0; gj < N; gj++) begin : g_err
         localparam logic [KW-1:0] K_LO = KW'(LAT + gj);
         localparam logic [KW-1:0] K_HI = KW'(LAT + gj + X_R - 1);
         assign w_lane_bad[gj] = ((r_k < K_LO) || (r_k > K_HI)) &&
                                 (|I_SA_OUT[gj*16 +: 16]);
      end
   endgenerate

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_err <= 1'b0;
      end else if (I_START_FLAG) begin
         r_err <= 1'b0;
      end else if (w_shift_acc && (|w_lane_bad)) begin
         r_err <= 1'b1;
      end
   end

   assign O_ERR = r_err;
`endif

endmodule
